// File: rtl/dct_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// dct_seq_pkg: shared state encoding and width helper for the DCT
// phase sequencer.  rev 1.0
// ----------------------------------------------------------------------
package dct_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Counter width for a modulus: max(1, clog2(n)).
  function automatic int seq_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_modn.sv
`default_nettype none
// ----------------------------------------------------------------------
// counter_modn: falling-edge modulo-N counter with clear and wrap flag.
// rev 1.0
// ----------------------------------------------------------------------
module counter_modn
  import dct_seq_pkg::*;
#(
  parameter int N = 2,
  localparam int W = seq_width(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         wrap
);

  logic at_max;

  assign at_max = (q == W'(N - 1));
  // Wrap is the enabled terminal step; it chains into the next counter.
  assign wrap   = en && at_max;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= at_max ? '0 : q + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dct_phase_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// dct_phase_sequencer: steps phase within block within frame, one-shot
// or free-running.  rev 1.0
// ----------------------------------------------------------------------
module dct_phase_sequencer
  import dct_seq_pkg::*;
#(
  parameter int PHASES     = 3,
  parameter int BLOCKS     = 8,
  parameter int CONTINUOUS = 0,
  localparam int PW = seq_width(PHASES),
  localparam int BW = seq_width(BLOCKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              en,
  input  logic              abort,
  output logic [PW-1:0]     phase,
  output logic [PHASES-1:0] phase_oh,
  output logic [BW-1:0]     blk,
  output logic              busy,
  output logic              last,
  output logic              done,
  output logic              frame_wrap
);

  seq_state_t state;
  logic       in_run;
  logic       cnt_clr;
  logic       phase_wrap;
  logic       frame_end;

  assign in_run  = (state == RUN);
  // Counters sit at zero outside RUN, so a start always begins at 0/0.
  assign cnt_clr = abort || !in_run;

  counter_modn #(.N(PHASES)) u_phase (
    .clk  (clk),
    .reset(reset),
    .en   (in_run && en),
    .clr  (cnt_clr),
    .q    (phase),
    .wrap (phase_wrap)
  );

  counter_modn #(.N(BLOCKS)) u_blk (
    .clk  (clk),
    .reset(reset),
    .en   (phase_wrap),
    .clr  (cnt_clr),
    .q    (blk),
    .wrap (frame_end)
  );

  assign last = in_run && (phase == PW'(PHASES - 1)) && (blk == BW'(BLOCKS - 1));

  always_comb begin
    phase_oh = '0;
    for (int i = 0; i < PHASES; i++) begin
      phase_oh[i] = in_run && (phase == PW'(i));
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_wrap <= 1'b0;
    end else begin
      done       <= 1'b0;
      frame_wrap <= 1'b0;
      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
          RUN: begin
            if (frame_end) begin
              if (CONTINUOUS != 0) begin
                frame_wrap <= 1'b1;
              end else begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          DONE: state <= IDLE;
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_phase_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_dct_phase_sequencer: three configurations driven in parallel and
// checked against a linear-position model.  rev 1.0
// ----------------------------------------------------------------------
module tb_dct_phase_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic en = 1'b0;
  logic abort = 1'b0;
  bit   chk = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic [1:0] ph0; logic [2:0] oh0; logic [2:0] bk0; logic bs0, ls0, dn0, fw0;
  logic [1:0] ph1; logic [3:0] oh1; logic [0:0] bk1; logic bs1, ls1, dn1, fw1;
  logic [0:0] ph2; logic [0:0] oh2; logic [1:0] bk2; logic bs2, ls2, dn2, fw2;

  dct_phase_sequencer #(.PHASES(3), .BLOCKS(8), .CONTINUOUS(0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .en(en), .abort(abort),
    .phase(ph0), .phase_oh(oh0), .blk(bk0), .busy(bs0), .last(ls0),
    .done(dn0), .frame_wrap(fw0));

  dct_phase_sequencer #(.PHASES(4), .BLOCKS(2), .CONTINUOUS(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .en(en), .abort(abort),
    .phase(ph1), .phase_oh(oh1), .blk(bk1), .busy(bs1), .last(ls1),
    .done(dn1), .frame_wrap(fw1));

  dct_phase_sequencer #(.PHASES(1), .BLOCKS(3), .CONTINUOUS(0)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .en(en), .abort(abort),
    .phase(ph2), .phase_oh(oh2), .blk(bk2), .busy(bs2), .last(ls2),
    .done(dn2), .frame_wrap(fw2));

  logic [31:0] a_ph[3], a_oh[3], a_bk[3], a_bs[3], a_ls[3], a_dn[3], a_fw[3];
  assign a_ph[0] = 32'(ph0); assign a_oh[0] = 32'(oh0); assign a_bk[0] = 32'(bk0);
  assign a_bs[0] = 32'(bs0); assign a_ls[0] = 32'(ls0); assign a_dn[0] = 32'(dn0);
  assign a_fw[0] = 32'(fw0);
  assign a_ph[1] = 32'(ph1); assign a_oh[1] = 32'(oh1); assign a_bk[1] = 32'(bk1);
  assign a_bs[1] = 32'(bs1); assign a_ls[1] = 32'(ls1); assign a_dn[1] = 32'(dn1);
  assign a_fw[1] = 32'(fw1);
  assign a_ph[2] = 32'(ph2); assign a_oh[2] = 32'(oh2); assign a_bk[2] = 32'(bk2);
  assign a_bs[2] = 32'(bs2); assign a_ls[2] = 32'(ls2); assign a_dn[2] = 32'(dn2);
  assign a_fw[2] = 32'(fw2);

  function automatic int np(input int k);
    return (k == 0) ? 3 : (k == 1) ? 4 : 1;
  endfunction
  function automatic int nb(input int k);
    return (k == 0) ? 8 : (k == 1) ? 2 : 3;
  endfunction
  function automatic bit nc(input int k);
    return (k == 1);
  endfunction

  task automatic cmp(input string nm, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0d want=%0d t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Model: state (0 idle, 1 run, 2 done) and a linear position in the frame.
  int m_st[3];
  int m_pos[3];
  bit m_done[3];
  bit m_fw[3];

  always @(negedge clk or negedge reset) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset) begin
        m_st[k] <= 0; m_pos[k] <= 0; m_done[k] <= 1'b0; m_fw[k] <= 1'b0;
      end else begin
        m_done[k] <= 1'b0;
        m_fw[k]   <= 1'b0;
        if (abort) begin
          m_st[k] <= 0; m_pos[k] <= 0;
        end else if (m_st[k] == 1) begin
          if (en) begin
            if (m_pos[k] == np(k) * nb(k) - 1) begin
              m_pos[k] <= 0;
              if (nc(k)) m_fw[k] <= 1'b1;
              else begin m_st[k] <= 2; m_done[k] <= 1'b1; end
            end else begin
              m_pos[k] <= m_pos[k] + 1;
            end
          end
        end else if (m_st[k] == 2) begin
          m_st[k] <= 0;
        end else if (start) begin
          m_st[k] <= 1; m_pos[k] <= 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (chk) begin
      for (int k = 0; k < 3; k++) begin
        cmp("phase", k, a_ph[k], 32'(m_pos[k] % np(k)));
        cmp("blk", k, a_bk[k], 32'(m_pos[k] / np(k)));
        cmp("phase_oh", k, a_oh[k], (m_st[k] == 1) ? (32'd1 << (m_pos[k] % np(k))) : 32'd0);
        cmp("busy", k, a_bs[k], 32'(m_st[k] == 1));
        cmp("last", k, a_ls[k], 32'(m_st[k] == 1 && m_pos[k] == np(k) * nb(k) - 1));
        cmp("done", k, a_dn[k], 32'(m_done[k]));
        cmp("frame_wrap", k, a_fw[k], 32'(m_fw[k]));
      end
    end
  end

  // Called at posedge+1; clears all instances with abort, then starts a frame.
  task automatic frame(input bit toggle, input int abort_c, input int ncyc,
                       output int busy0, output int done0, output int fwc1,
                       output int done2, output int blk2_at3, output int ph0_at4);
    abort = 1'b1; start = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b1; en = 1'b1;
    busy0 = 0; done0 = 0; fwc1 = 0; done2 = 0; blk2_at3 = -1; ph0_at4 = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (bs0) busy0++;
      if (dn0 && done0 == 0) done0 = c;
      if (fw1) fwc1++;
      if (dn2 && done2 == 0) done2 = c;
      if (c == 3) blk2_at3 = int'(bk2);
      if (c == 4) ph0_at4 = int'(ph0);
      en = toggle ? (c % 2 == 1) : 1'b1;
      abort = (c == abort_c);
    end
    abort = 1'b0; en = 1'b0;
  endtask

  int busy0, done0, fwc1, done2, blk2_at3, ph0_at4;

  initial begin
    #1 reset = 1'b0;
    #1 chk = 1'b1;
    @(posedge clk); #1;
    cmp("reset_busy", 0, 32'(bs0), 32'd0);
    cmp("reset_phase", 0, 32'(ph0), 32'd0);
    reset = 1'b1;

    // En held high on all three configurations.
    frame(1'b0, 0, 30, busy0, done0, fwc1, done2, blk2_at3, ph0_at4);
    cmp("busy_cycles", 0, busy0, 24);
    cmp("done_cycle", 0, done0, 25);
    cmp("phase_wrap_c4", 0, ph0_at4, 0);
    cmp("wrap_pulses", 1, fwc1, 3);
    cmp("done_cycle", 2, done2, 4);
    cmp("blk_c3", 2, blk2_at3, 2);

    // En alternating 1,0: 24 enabled edges spread over 47 cycles.
    frame(1'b1, 0, 50, busy0, done0, fwc1, done2, blk2_at3, ph0_at4);
    cmp("busy_cycles_toggle", 0, busy0, 47);
    cmp("done_cycle_toggle", 0, done0, 48);
    cmp("phase_c4_toggle", 0, ph0_at4, 2);
    cmp("wrap_pulses_toggle", 1, fwc1, 3);
    cmp("done_cycle_toggle", 2, done2, 6);
    cmp("blk_c3_toggle", 2, blk2_at3, 1);

    // Abort coincident with the last step.
    frame(1'b0, 24, 30, busy0, done0, fwc1, done2, blk2_at3, ph0_at4);
    cmp("abort_busy", 0, busy0, 24);
    cmp("abort_done", 0, done0, 0);
    cmp("abort_wraps", 1, fwc1, 2);

    // Reset dropped between edges mid-run.
    frame(1'b0, 0, 6, busy0, done0, fwc1, done2, blk2_at3, ph0_at4);
    #2 reset = 1'b0;
    #1;
    cmp("async_busy", 0, 32'(bs0), 32'd0);
    cmp("async_phase", 0, 32'(ph0), 32'd0);
    cmp("async_blk", 0, 32'(bk0), 32'd0);
    cmp("async_busy", 1, 32'(bs1), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    frame(1'b0, 0, 30, busy0, done0, fwc1, done2, blk2_at3, ph0_at4);
    cmp("post_reset_done", 0, done0, 25);
    cmp("post_reset_busy", 0, busy0, 24);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 7) == 0);
      en    = ($urandom_range(0, 3) != 0);
      abort = ($urandom_range(0, 31) == 0);
    end
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dct_phase_sequencer.md
DCT_PHASE_SEQUENCER -- requirements
Module: dct_phase_sequencer

Interface
REQ-001 Parameter PHASES, default 3, sets the number of phases per block; legal range 1..16.
REQ-002 Parameter BLOCKS, default 8, sets the number of blocks per frame; legal range 1..256.
REQ-003 Parameter CONTINUOUS, default 0, selects the run mode: 0 = one-shot frame, 1 = free-running frames.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on the falling edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: begins a frame when the block is IDLE.
REQ-007 Port en, input, 1 bit: advance qualifier; low SHALL freeze all counters while in RUN.
REQ-008 Port abort, input, 1 bit: synchronous return to IDLE.
REQ-009 Port phase, output, PW = max(1, clog2(PHASES)) bits: current phase index.
REQ-010 Port phase_oh, output, PHASES bits: one-hot decode of phase; SHALL be all-zero when not in RUN.
REQ-011 Port blk, output, BW = max(1, clog2(BLOCKS)) bits: current block index.
REQ-012 Port busy, output, 1 bit: high while in RUN.
REQ-013 Port last, output, 1 bit: combinational; high in RUN when phase = PHASES-1 and blk = BLOCKS-1.
REQ-014 Port done, output, 1 bit: one-cycle pulse at frame completion.
REQ-015 Port frame_wrap, output, 1 bit: one-cycle pulse at each frame rollover when CONTINUOUS = 1.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 Transition precedence at each falling edge SHALL be: abort, then state-specific rules.
REQ-018 IDLE with start = 1 SHALL go to RUN at the next edge, with phase = 0 and blk = 0.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 In RUN with en = 1 and phase < PHASES-1, phase SHALL increment by 1.
REQ-021 In RUN with en = 1 and phase = PHASES-1, phase SHALL wrap to 0 and blk SHALL increment by 1.
REQ-022 At the last step (last = 1, en = 1) with CONTINUOUS = 0, the block SHALL go to DONE with phase and blk cleared and done = 1 for exactly one cycle.
REQ-023 At the last step (last = 1, en = 1) with CONTINUOUS = 1, the block SHALL stay in RUN, clear phase and blk, and pulse frame_wrap once; done SHALL never assert in this mode.
REQ-024 DONE SHALL go to IDLE unconditionally at the next edge; a start in that cycle is dropped.
REQ-025 With PHASES = 1, phase SHALL stay 0 and blk SHALL advance on every enabled edge; BLOCKS = 1 is handled analogously.
REQ-026 abort = 1 in any state SHALL give IDLE at the next edge with all outputs at their reset values; abort SHALL override a coincident last step, so done and frame_wrap stay 0.
REQ-027 All outputs except last and phase_oh SHALL be registered.
REQ-028 Counter arithmetic SHALL be unsigned with no overflow past PHASES-1 or BLOCKS-1.

Reset
REQ-029 reset = 0 SHALL immediately force IDLE, phase = 0, blk = 0, busy = 0, done = 0 and frame_wrap = 0, independent of clk.
REQ-030 Deassertion of reset SHALL take effect at the next falling edge; the block SHALL leave IDLE only on start.

Structure
REQ-031 Package dct_seq_pkg SHALL hold the state enumeration (IDLE, RUN, DONE) and the PW/BW width-function constants.
REQ-032 The sub-module counter_modn (parameter N; inputs clk, reset, en, clr; outputs q and wrap) SHALL be instantiated twice: once for phase and once for blk, with the phase wrap output driving the blk enable.

Verification
REQ-033 Defaults, start pulse, en held at 1: phase sequence 0,1,2,0,... over 24 cycles; blk reaches 7; done pulses on cycle 25; busy is high for 24 cycles.
REQ-034 en toggled 1,0,1,0 during RUN: phase and blk hold in every en = 0 cycle; total run length is 24 enabled cycles.
REQ-035 abort asserted at phase = 2, blk = 7 with en = 1: next state is IDLE; done and frame_wrap stay 0.
REQ-036 CONTINUOUS = 1, PHASES = 4, BLOCKS = 2: frame_wrap pulses every 8 enabled cycles; done stays 0.
REQ-037 reset driven low between clock edges mid-RUN: outputs clear immediately; a start after release runs a full frame.
REQ-038 PHASES = 1, BLOCKS = 3: phase stays 0, blk follows 0,1,2, and done pulses after 3 enabled cycles.
